// File: rtl/ahb_cmd_arbiter.sv
// Two-requester round-robin command arbiter in front of an AHB master controller.
// Latency: req sampled in IDLE -> gnt next cycle -> start the cycle after (mst_busy=0).
// Backpressure: mst_busy holds the command in ISSUE; a WAIT watchdog aborts after TIMEOUT cycles.
//
// Ports:
//   HCLK, HRESETn                    bus clock, async active-low reset
//   req/wr/burst/len/addr 0 and 1    requester command inputs (req held until gnt)
//   gnt0/gnt1, done0/done1           one-cycle accept / completion pulses per requester
//   start, write, burst, burst_len,  command to the master controller; fields hold
//   haddr                            from grant until the next grant
//   mst_busy, mst_done               master controller status
//   owner                            current or last granted requester
//   timeout_err                      one-cycle pulse on watchdog abort
module ahb_cmd_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0,
  input  logic        wr0,
  input  logic [2:0]  burst0,
  input  logic [3:0]  len0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [2:0]  burst1,
  input  logic [3:0]  len1,
  input  logic [31:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        start,
  output logic        write,
  output logic [2:0]  burst,
  output logic [3:0]  burst_len,
  output logic [31:0] haddr,
  input  logic        mst_busy,
  input  logic        mst_done,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // The watchdog fires on the edge where the counter would reach TIMEOUT,
  // so the abort pulse appears TIMEOUT cycles after WAIT entry.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_d, write_d, start_d, tout_d;
  logic        gnt0_d, gnt1_d, done0_d, done1_d;
  logic [2:0]  burst_d;
  logic [3:0]  blen_d;
  logic [31:0] addr_d;
  logic        win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner;
    write_d = write;
    burst_d = burst;
    blen_d  = burst_len;
    addr_d  = haddr;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    start_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    tout_d  = 1'b0;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        // Skipping the cycle in which done is still high guarantees at least
        // one quiet cycle between a completion and the next grant.
        if ((req0 || req1) && !(done0 || done1)) begin
          // On a tie the requester that did not win last time goes first.
          win     = (req0 && req1) ? ~last_q : req1;
          last_d  = win;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          write_d = win ? wr1 : wr0;
          burst_d = win ? burst1 : burst0;
          addr_d  = win ? addr1 : addr0;
          // SINGLE bursts always carry one beat, whatever len says.
          if ((win ? burst1 : burst0) == 3'b000) blen_d = 4'd1;
          else                                   blen_d = win ? len1 : len0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (!mst_busy) begin
          start_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // mst_done wins over a simultaneous watchdog expiry.
        if (mst_done) begin
          done0_d = ~owner;
          done1_d = owner;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          done0_d = ~owner;
          done1_d = owner;
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      last_q      <= 1'b1;
      owner       <= 1'b0;
      write       <= 1'b0;
      burst       <= 3'b000;
      burst_len   <= 4'd0;
      haddr       <= 32'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      start       <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner       <= owner_d;
      write       <= write_d;
      burst       <= burst_d;
      burst_len   <= blen_d;
      haddr       <= addr_d;
      gnt0        <= gnt0_d;
      gnt1        <= gnt1_d;
      start       <= start_d;
      done0       <= done0_d;
      done1       <= done1_d;
      timeout_err <= tout_d;
    end
  end

endmodule

// File: doc/ahb_cmd_arbiter.md
AHB_CMD_ARBITER -- requirements
Module: ahb_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the HCLK cycles allowed in WAIT before abort (8-bit counter).
REQ-002 SHALL have port HCLK  input  1  bus clock; all state changes on the rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0/req1  input  1  requester N asks for a transfer; held high until grant.
REQ-005 SHALL have ports wr0/wr1  input  1  requester N direction (1 write, 0 read).
REQ-006 SHALL have ports burst0/burst1  input  3  requester N burst type (000 = SINGLE).
REQ-007 SHALL have ports len0/len1  input  4  requester N beat count.
REQ-008 SHALL have ports addr0/addr1  input  32  requester N start address.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse; the command is accepted.
REQ-010 SHALL have ports done0/done1  output  1  one-cycle pulse; requester N's transfer has ended.
REQ-011 SHALL have ports start, write, burst[2:0], burst_len[3:0], haddr[31:0]  output  command to the master controller.
REQ-012 SHALL have ports mst_busy, mst_done  input  1  master controller busy level and done pulse.
REQ-013 SHALL have port owner  output  1  index of the current or last granted requester.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ISSUE, WAIT.
REQ-016 IDLE: if req0 or req1 is high, SHALL select a winner, latch its wr/burst/len/addr, pulse its gnt, set owner, and go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both requests are high, the requester not equal to last_owner wins; a sole requester always wins.
REQ-018 last_owner SHALL update only on grant, so that req0 wins the first tie after reset.
REQ-019 ISSUE: when mst_busy=0, SHALL pulse start for one cycle with the latched command on write/burst/burst_len/haddr, then go to WAIT; while mst_busy=1, SHALL hold in ISSUE with start=0.
REQ-020 When the latched burst is 000, burst_len SHALL be driven as 1, regardless of the latched len.
REQ-021 write/burst/burst_len/haddr SHALL hold the latched values from grant until the next grant.
REQ-022 WAIT: on mst_done, SHALL pulse done<owner> for one cycle and return to IDLE.
REQ-023 WAIT: an 8-bit counter SHALL clear on entry and increment each cycle; on reaching TIMEOUT without mst_done, SHALL pulse timeout_err and done<owner> together and return to IDLE.
REQ-024 If mst_done and the timeout occur in the same cycle, done SHALL take priority and timeout_err SHALL stay 0.
REQ-025 Latency: req high in IDLE at edge N -> gnt at N+1 -> start at N+2, given mst_busy=0.
REQ-026 A request arriving while in ISSUE or WAIT SHALL be serviced only after the return to IDLE, with a minimum one-cycle bubble between done and the next gnt.
REQ-027 A req deasserted before grant SHALL be ignored; gnt SHALL never pulse for a low req.
REQ-028 mst_done received outside WAIT SHALL be ignored.

Reset
REQ-029 While HRESETn=0: state=IDLE; start, gnt0/1, done0/1, timeout_err, owner and counter SHALL all be 0; last_owner=1; write/burst/burst_len/haddr SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the command without pulsing done or timeout_err.

Verification
REQ-031 Only req0 (wr0=1, burst0=011, len0=4, addr0=0x100) -> gnt0 at +1, start at +2 with haddr=0x100 and burst_len=4; mst_done -> done0 next edge.
REQ-032 req0 and req1 both high, held across two transfers -> first gnt0, then gnt1; owner 0 then 1.
REQ-033 burst1=000 with len1=7 -> burst_len=1 on start.
REQ-034 mst_busy=1 for 3 cycles in ISSUE -> start is delayed exactly 3 cycles.
REQ-035 TIMEOUT=8 and no mst_done -> timeout_err and done0 pulse 8 cycles after WAIT entry; FSM back in IDLE.
REQ-036 HRESETn pulsed low during WAIT -> all outputs 0; the next tie is granted to req0.
